// File: rtl/alu_cmd_seq_if.sv
// Bundles the command, ALU and result signals of alu_cmd_seq.
// The slave modport is the sequencer; master is its environment.
interface alu_cmd_seq_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [1:0]       in_op;
  logic             in_chain;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [1:0]       alu_op;
  logic             alu_en;
  logic [31:0]      alu_c;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_chain, alu_c, out_ready,
    output in_ready, alu_a, alu_b, alu_op, alu_en, out_valid, out_data, op_count
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_chain, alu_c, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, alu_en, out_valid, out_data, op_count
  );
endinterface

// File: rtl/alu_cmd_seq.sv
// Command sequencer for a registered ALU: accepts one command, pulses the ALU
// for one cycle, waits ALU_LAT cycles, then offers the result downstream.
module alu_cmd_seq #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic          clk,
  input  logic          reset,
  alu_cmd_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      a_q, a_nxt;
  logic [31:0]      b_q, b_nxt;
  logic [1:0]       op_q, op_nxt;
  logic             en_q, en_nxt;
  logic [31:0]      data_q, data_nxt;
  logic             valid_q, valid_nxt;
  logic [31:0]      last_q, last_nxt;
  logic             have_q, have_nxt;
  logic [3:0]       wait_q, wait_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= '0;
      have_q  <= 1'b0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      op_q    <= op_nxt;
      en_q    <= en_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      last_q  <= last_nxt;
      have_q  <= have_nxt;
      wait_q  <= wait_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    op_nxt    = op_q;
    en_nxt    = en_q;
    data_nxt  = data_q;
    valid_nxt = valid_q;
    last_nxt  = last_q;
    have_nxt  = have_q;
    wait_nxt  = wait_q;
    cnt_nxt   = cnt_q;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          a_nxt     = (bus.in_chain && have_q) ? last_q : bus.in_a;
          b_nxt     = bus.in_b;
          op_nxt    = bus.in_op;
          en_nxt    = 1'b1;
          wait_nxt  = 4'(ALU_LAT);
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        en_nxt    = 1'b0;
        state_nxt = WAIT;
      end
      WAIT: begin
        wait_nxt = wait_q - 4'd1;
        // wait_cnt == 1 marks the last latency cycle: c is valid now.
        if (wait_q == 4'd1) begin
          data_nxt  = bus.alu_c;
          valid_nxt = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          valid_nxt = 1'b0;
          last_nxt  = data_q;
          have_nxt  = 1'b1;
          cnt_nxt   = cnt_q + CNT_W'(1);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_en    = en_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Scoreboard bench for alu_cmd_seq with a behavioural ALU and a chaining model.
module tb_alu_cmd_seq;
  localparam int unsigned ALU_LAT = 3;
  localparam int unsigned CNT_W   = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    int          acc_cyc;
  } cmd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  cmd_t issue_q[$];
  cmd_t res_q[$];
  logic [31:0]      last_m = '0;
  logic             have_m = 1'b0;
  logic [CNT_W-1:0] cnt_m = '0;
  logic             rdy_auto = 1'b0;
  logic             rdy_force = 1'b1;

  alu_cmd_seq_if #(.CNT_W(CNT_W)) bus ();

  alu_cmd_seq #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // Registered ALU; c is only meaningful in the cycle it is due, garbage otherwise.
  logic [31:0] pipe [ALU_LAT];
  always @(posedge clk) begin
    for (int i = ALU_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= bus.alu_en ? alu_ref(bus.alu_a, bus.alu_b, bus.alu_op)
                          : (32'hDEAD_BEEF ^ 32'(cyc));
  end
  assign bus.alu_c = pipe[ALU_LAT-1];

  always @(posedge clk) begin
    #1;
    bus.out_ready = rdy_auto ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: ALU-side pulses, result timing, result data and completion count.
  logic prev_en = 1'b0, prev_ov = 1'b0, pend_cnt = 1'b0;
  always @(negedge clk) begin
    cmd_t e;
    if (reset) begin
      prev_en  = 1'b0;
      prev_ov  = 1'b0;
      pend_cnt = 1'b0;
      cnt_m    = '0;
    end else begin
      if (pend_cnt) begin
        chk("op_count", 32'(bus.op_count), 32'(cnt_m));
        pend_cnt = 1'b0;
      end
      if (bus.alu_en) begin
        if (prev_en) fail("alu_en_longer_than_one_cycle");
        if (issue_q.size() == 0) fail("alu_en_without_command");
        else begin
          e = issue_q.pop_front();
          chk("alu_a", bus.alu_a, e.a);
          chk("alu_b", bus.alu_b, e.b);
          chk("alu_op", 32'(bus.alu_op), 32'(e.op));
          chk("issue_cycle", 32'(cyc), 32'(e.acc_cyc));
        end
      end
      if (bus.out_valid && !prev_ov) begin
        if (res_q.size() == 0) fail("out_valid_without_command");
        else chk("result_latency", 32'(cyc), 32'(res_q[0].acc_cyc + 1 + int'(ALU_LAT)));
      end
      if (bus.out_valid && bus.out_ready && res_q.size() != 0) begin
        e = res_q.pop_front();
        chk("out_data", bus.out_data, e.res);
        cnt_m    = cnt_m + 1'b1;
        pend_cnt = 1'b1;
      end
      prev_en = bus.alu_en;
      prev_ov = bus.out_valid;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic ch);
    cmd_t e;
    int unsigned n = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_chain = ch;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      fail("accept_timeout");
      bus.in_valid = 1'b0;
      return;
    end
    e.a  = (ch && have_m) ? last_m : a;
    e.b  = b;
    e.op = op;
    e.res = alu_ref(e.a, e.b, e.op);
    @(posedge clk); #1;
    e.acc_cyc = cyc;
    issue_q.push_back(e);
    res_q.push_back(e);
    last_m = e.res;
    have_m = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    bus.in_op    = 2'($urandom);
    bus.in_chain = 1'($urandom);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (res_q.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (res_q.size() != 0) fail("drain_timeout");
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    issue_q.delete();
    res_q.delete();
    have_m = 1'b0;
    last_m = '0;
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_alu_en"}, 32'(bus.alu_en), 32'd0);
    chk({tag, "_op_count"}, 32'(bus.op_count), 32'd0);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int unsigned n;
    logic [CNT_W-1:0] wrap_exp;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_op    = '0;
    bus.in_chain = 1'b0;
    bus.out_ready = 1'b1;

    do_reset();
    chk_idle("reset");
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_alu_a", bus.alu_a, 32'd0);
    chk("reset_alu_b", bus.alu_b, 32'd0);
    chk("reset_alu_op", 32'(bus.alu_op), 32'd0);

    send(32'd5, 32'd3, 2'd0, 1'b0);
    drain();
    chk("add_op_count", 32'(bus.op_count), 32'd1);
    send(32'd3, 32'd5, 2'd1, 1'b0);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 2'd2, 1'b0);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 2'd3, 1'b0);
    send(32'd5, 32'd3, 2'd0, 1'b0);
    send(32'd100, 32'd2, 2'd1, 1'b1);
    drain();

    do_reset();
    send(32'd7, 32'd1, 2'd0, 1'b1);
    drain();

    // Backpressure: result must hold while the consumer stalls.
    rdy_force = 1'b0;
    send(32'd1, 32'd2, 2'd0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.out_valid) fail("bp_out_valid_timeout");
    held = bus.out_data;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.in_valid = i[0];
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data", bus.out_data, held);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_alu_en", 32'(bus.alu_en), 32'd0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rdy_force = 1'b1;
    drain();

    // Abandon a command while it waits on the ALU.
    do_reset();
    send(32'd9, 32'd4, 2'd1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    issue_q.delete();
    res_q.delete();
    have_m = 1'b0;
    last_m = '0;
    chk_idle("midop_reset");

    // Counter wraps at 2^CNT_W.
    for (int i = 0; i < 5; i++) begin
      send($urandom, $urandom, 2'($urandom), 1'b0);
      drain();
      wrap_exp = CNT_W'(i + 1);
      chk("wrap_op_count", 32'(bus.op_count), 32'(wrap_exp));
    end

    rdy_auto = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(rnd32(), rnd32(), 2'($urandom), ($urandom_range(0, 2) == 0));
    end
    drain();
    rdy_auto = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
